// File: rtl/uart_tx_queue.sv
// Byte queue feeding a UART transmitter through a three-state send handshake.
// Circular buffer of DEPTH bytes; every output is driven from a register.
module uart_tx_queue #(
  parameter  int unsigned DEPTH = 16,
  localparam int unsigned CW    = $clog2(DEPTH) + 1
) (
  input  logic          clk,
  input  logic          rst,
  input  logic [7:0]    wr_data,
  input  logic          wr_en,
  output logic          full,
  output logic          empty,
  output logic [CW-1:0] count,
  output logic          overflow,
  output logic [7:0]    tx_d,
  output logic          tx_send,
  input  logic          tx_rdy
);

  localparam int unsigned AW = $clog2(DEPTH);

  typedef enum logic [1:0] {
    IDLE,
    SETUP,
    STROBE
  } state_e;

  logic [7:0]    mem_q [DEPTH];
  logic [AW-1:0] wr_ptr_q, wr_ptr_d;
  logic [AW-1:0] rd_ptr_q, rd_ptr_d;
  logic [CW-1:0] count_q, count_d;
  logic          full_q, empty_q, overflow_q;
  state_e        state_q, state_d;
  logic [7:0]    tx_d_q, tx_d_d;
  logic          tx_send_q, tx_send_d;
  logic          accept, pop;

  // Full comes from the registered count, so a write on a pop cycle while full is refused.
  always_comb begin
    accept = wr_en && !full_q;
    pop    = (state_q == IDLE) && !empty_q && tx_rdy;
  end

  always_comb begin
    wr_ptr_d = accept ? wr_ptr_q + AW'(1) : wr_ptr_q;
    rd_ptr_d = pop    ? rd_ptr_q + AW'(1) : rd_ptr_q;
    count_d  = count_q;
    case ({accept, pop})
      2'b10:   count_d = count_q + CW'(1);
      2'b01:   count_d = count_q - CW'(1);
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      count_q    <= '0;
      full_q     <= 1'b0;
      empty_q    <= 1'b1;
      overflow_q <= 1'b0;
    end else begin
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      count_q    <= count_d;
      full_q     <= (count_d == CW'(DEPTH));
      empty_q    <= (count_d == '0);
      overflow_q <= wr_en && full_q;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst && accept) begin
      mem_q[wr_ptr_q] <= wr_data;
    end
  end

  // Sender FSM: state and registered outputs.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= IDLE;
      tx_d_q    <= '0;
      tx_send_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      tx_d_q    <= tx_d_d;
      tx_send_q <= tx_send_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (pop) state_d = SETUP;
      SETUP:   state_d = STROBE;
      STROBE:  if (!tx_rdy) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Next values of the registered outputs; tx_send is high exactly while in STROBE.
  always_comb begin
    tx_d_d    = tx_d_q;
    tx_send_d = 1'b0;
    if (pop) begin
      tx_d_d = mem_q[rd_ptr_q];
    end
    case (state_q)
      SETUP:   tx_send_d = 1'b1;
      STROBE:  tx_send_d = tx_rdy;
      default: tx_send_d = 1'b0;
    endcase
  end

  assign full     = full_q;
  assign empty    = empty_q;
  assign count    = count_q;
  assign overflow = overflow_q;
  assign tx_d     = tx_d_q;
  assign tx_send  = tx_send_q;

endmodule

// File: tb/tb_uart_tx_queue.sv
// Directed self-checking bench for uart_tx_queue with DEPTH=16.
module tb_uart_tx_queue;

  localparam int unsigned DEPTH = 16;
  localparam int unsigned CW    = $clog2(DEPTH) + 1;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic [7:0]    wr_data = 8'h00;
  logic          wr_en = 1'b0;
  logic          full, empty, overflow, tx_send;
  logic [CW-1:0] count;
  logic [7:0]    tx_d;
  logic          tx_rdy = 1'b0;

  int unsigned pass_cnt = 0;
  int unsigned total_cnt = 0;

  uart_tx_queue #(.DEPTH(DEPTH)) dut (
    .clk      (clk),
    .rst      (rst),
    .wr_data  (wr_data),
    .wr_en    (wr_en),
    .full     (full),
    .empty    (empty),
    .count    (count),
    .overflow (overflow),
    .tx_d     (tx_d),
    .tx_send  (tx_send),
    .tx_rdy   (tx_rdy)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic apply_reset();
    rst   = 1'b1;
    wr_en = 1'b0;
    tick();
    rst = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1; wr_en = 1'b1; wr_data = 8'hA5; tx_rdy = 1'b1;
    tick(); tick();
    total_cnt++; if (count !== 5'd0) $display("FAIL reset_count got %0d want 0", count); else pass_cnt++;
    total_cnt++; if (empty !== 1'b1) $display("FAIL reset_empty got %b want 1", empty); else pass_cnt++;
    total_cnt++; if (full !== 1'b0) $display("FAIL reset_full got %b want 0", full); else pass_cnt++;
    total_cnt++; if (overflow !== 1'b0) $display("FAIL reset_overflow got %b want 0", overflow); else pass_cnt++;
    total_cnt++; if (tx_d !== 8'h00) $display("FAIL reset_tx_d got %h want 00", tx_d); else pass_cnt++;
    total_cnt++; if (tx_send !== 1'b0) $display("FAIL reset_tx_send got %b want 0", tx_send); else pass_cnt++;
    rst = 1'b0; wr_en = 1'b0;
    tick(); tick();
    total_cnt++; if (count !== 5'd0) $display("FAIL reset_no_enqueue got %0d want 0", count); else pass_cnt++;
    total_cnt++; if (tx_send !== 1'b0) $display("FAIL reset_no_send got %b want 0", tx_send); else pass_cnt++;
  endtask

  task automatic test_latency();
    tx_rdy = 1'b1; wr_en = 1'b1; wr_data = 8'h55;
    tick();
    wr_en = 1'b0;
    total_cnt++; if (count !== 5'd1) $display("FAIL lat_count1 got %0d want 1", count); else pass_cnt++;
    total_cnt++; if (tx_send !== 1'b0) $display("FAIL lat_send_c1 got %b want 0", tx_send); else pass_cnt++;
    tick();
    total_cnt++; if (tx_send !== 1'b0) $display("FAIL lat_send_c2 got %b want 0", tx_send); else pass_cnt++;
    total_cnt++; if (tx_d !== 8'h55) $display("FAIL lat_tx_d_pop got %h want 55", tx_d); else pass_cnt++;
    total_cnt++; if (count !== 5'd0) $display("FAIL lat_count_pop got %0d want 0", count); else pass_cnt++;
    tick();
    total_cnt++; if (tx_send !== 1'b1) $display("FAIL lat_send_c3 got %b want 1", tx_send); else pass_cnt++;
    total_cnt++; if (tx_d !== 8'h55) $display("FAIL lat_tx_d_strobe got %h want 55", tx_d); else pass_cnt++;
    tx_rdy = 1'b0;
    tick();
    total_cnt++; if (tx_send !== 1'b0) $display("FAIL lat_send_fall got %b want 0", tx_send); else pass_cnt++;
    total_cnt++; if (tx_d !== 8'h55) $display("FAIL lat_tx_d_hold got %h want 55", tx_d); else pass_cnt++;
  endtask

  task automatic test_full_overflow();
    int unsigned got;
    logic [7:0]  exp;
    logic        extra;
    tx_rdy = 1'b0;
    apply_reset();
    for (int i = 0; i < 16; i++) begin
      wr_en = 1'b1; wr_data = 8'(i + 1);
      tick();
    end
    total_cnt++; if (full !== 1'b1) $display("FAIL full_flag got %b want 1", full); else pass_cnt++;
    total_cnt++; if (count !== 5'd16) $display("FAIL full_count got %0d want 16", count); else pass_cnt++;
    wr_data = 8'h11;
    tick();
    wr_en = 1'b0;
    total_cnt++; if (overflow !== 1'b1) $display("FAIL ovf_pulse got %b want 1", overflow); else pass_cnt++;
    total_cnt++; if (count !== 5'd16) $display("FAIL ovf_count got %0d want 16", count); else pass_cnt++;
    tick();
    total_cnt++; if (overflow !== 1'b0) $display("FAIL ovf_one_cycle got %b want 0", overflow); else pass_cnt++;
    // write while full on the pop cycle must be refused
    tx_rdy = 1'b1; wr_en = 1'b1; wr_data = 8'hAA;
    tick();
    wr_en = 1'b0;
    total_cnt++; if (count !== 5'd15) $display("FAIL popfull_count got %0d want 15", count); else pass_cnt++;
    total_cnt++; if (overflow !== 1'b1) $display("FAIL popfull_overflow got %b want 1", overflow); else pass_cnt++;
    total_cnt++; if (tx_d !== 8'h01) $display("FAIL popfull_tx_d got %h want 01", tx_d); else pass_cnt++;
    got = 0; exp = 8'h01;
    for (int c = 0; c < 300 && got < 16; c++) begin
      if (tx_send === 1'b1 && tx_rdy === 1'b1) begin
        total_cnt++; if (tx_d !== exp) $display("FAIL drain_byte%0d got %h want %h", got, tx_d, exp); else pass_cnt++;
        exp++; got++;
        tx_rdy = 1'b0;
      end else begin
        tx_rdy = 1'b1;
      end
      tick();
    end
    total_cnt++; if (got !== 16) $display("FAIL drain_total got %0d want 16", got); else pass_cnt++;
    tx_rdy = 1'b1; extra = 1'b0;
    for (int c = 0; c < 8; c++) begin
      tick();
      if (tx_send === 1'b1) extra = 1'b1;
    end
    total_cnt++; if (extra !== 1'b0) $display("FAIL drain_no_extra got %b want 0", extra); else pass_cnt++;
    total_cnt++; if (empty !== 1'b1) $display("FAIL drain_empty got %b want 1", empty); else pass_cnt++;
  endtask

  task automatic test_simultaneous();
    tx_rdy = 1'b0;
    apply_reset();
    for (int i = 0; i < 5; i++) begin
      wr_en = 1'b1; wr_data = 8'(8'h21 + i);
      tick();
    end
    wr_en = 1'b0;
    total_cnt++; if (count !== 5'd5) $display("FAIL simul_pre got %0d want 5", count); else pass_cnt++;
    tx_rdy = 1'b1; wr_en = 1'b1; wr_data = 8'h26;
    tick();
    wr_en = 1'b0; tx_rdy = 1'b0;
    total_cnt++; if (count !== 5'd5) $display("FAIL simul_count got %0d want 5", count); else pass_cnt++;
    total_cnt++; if (tx_d !== 8'h21) $display("FAIL simul_tx_d got %h want 21", tx_d); else pass_cnt++;
    tick();
    total_cnt++; if (count !== 5'd5) $display("FAIL simul_hold got %0d want 5", count); else pass_cnt++;
  endtask

  task automatic test_back_to_back();
    int unsigned widx, ridx;
    logic [7:0]  exp;
    tx_rdy = 1'b1;
    apply_reset();
    widx = 0; ridx = 0;
    for (int c = 0; c < 600 && ridx < 40; c++) begin
      if (widx < 40 && full !== 1'b1) begin
        wr_en = 1'b1; wr_data = 8'(widx * 37 + 3);
        widx++;
      end else begin
        wr_en = 1'b0;
      end
      if (tx_send === 1'b1 && tx_rdy === 1'b1) begin
        exp = 8'(ridx * 37 + 3);
        total_cnt++; if (tx_d !== exp) $display("FAIL order_byte%0d got %h want %h", ridx, tx_d, exp); else pass_cnt++;
        ridx++;
        tx_rdy = 1'b0;
      end else begin
        tx_rdy = 1'b1;
      end
      tick();
    end
    wr_en = 1'b0; tx_rdy = 1'b1;
    tick(); tick();
    total_cnt++; if (ridx !== 40) $display("FAIL order_total got %0d want 40", ridx); else pass_cnt++;
    total_cnt++; if (empty !== 1'b1) $display("FAIL order_empty got %b want 1", empty); else pass_cnt++;
    total_cnt++; if (count !== 5'd0) $display("FAIL order_count got %0d want 0", count); else pass_cnt++;
  endtask

  task automatic test_reset_strobe();
    logic seen;
    tx_rdy = 1'b0;
    apply_reset();
    for (int i = 0; i < 4; i++) begin
      wr_en = 1'b1; wr_data = 8'(8'h31 + i);
      tick();
    end
    wr_en = 1'b0; tx_rdy = 1'b1;
    tick(); tick();
    total_cnt++; if (tx_send !== 1'b1) $display("FAIL rststb_pre_send got %b want 1", tx_send); else pass_cnt++;
    total_cnt++; if (count !== 5'd3) $display("FAIL rststb_pre_count got %0d want 3", count); else pass_cnt++;
    rst = 1'b1;
    tick();
    rst = 1'b0;
    total_cnt++; if (tx_send !== 1'b0) $display("FAIL rststb_send got %b want 0", tx_send); else pass_cnt++;
    total_cnt++; if (count !== 5'd0) $display("FAIL rststb_count got %0d want 0", count); else pass_cnt++;
    total_cnt++; if (empty !== 1'b1) $display("FAIL rststb_empty got %b want 1", empty); else pass_cnt++;
    seen = 1'b0;
    for (int c = 0; c < 12; c++) begin
      tick();
      if (tx_send === 1'b1) seen = 1'b1;
    end
    total_cnt++; if (seen !== 1'b0) $display("FAIL rststb_no_send got %b want 0", seen); else pass_cnt++;
    total_cnt++; if (count !== 5'd0) $display("FAIL rststb_count_after got %0d want 0", count); else pass_cnt++;
  endtask

  initial begin
    test_reset();
    test_latency();
    test_full_overflow();
    test_simultaneous();
    test_back_to_back();
    test_reset_strobe();
    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule

// File: doc/uart_tx_queue.md
UART_TX_QUEUE -- requirements
Module: uart_tx_queue

Interface
REQ-001 SHALL have parameter DEPTH, default 16, meaning the number of byte entries in the queue; legal values are powers of two, >= 2.
REQ-002 SHALL have parameter CW = $clog2(DEPTH)+1 as a derived localparam, meaning the count width; it SHALL NOT be overridable.
REQ-003 SHALL have port clk, input, 1, the single system clock; all logic is on its rising edge.
REQ-004 SHALL have port rst, input, 1, the reset; synchronous and active-high.
REQ-005 SHALL have port wr_data, input, 8, the byte to enqueue.
REQ-006 SHALL have port wr_en, input, 1, the enqueue request; accepted when full=0.
REQ-007 SHALL have port full, output, 1, asserted when count == DEPTH.
REQ-008 SHALL have port empty, output, 1, asserted when count == 0.
REQ-009 SHALL have port count, output, CW, the number of stored bytes, 0..DEPTH.
REQ-010 SHALL have port overflow, output, 1, a one-cycle pulse marking a rejected write.
REQ-011 SHALL have port tx_d, output, 8, the byte presented to the downstream transmitter data input.
REQ-012 SHALL have port tx_send, output, 1, the rising-edge send strobe to the downstream transmitter.
REQ-013 SHALL have port tx_rdy, input, 1, the downstream transmitter ready; high means a send rising edge will be accepted.

Function
REQ-014 SHALL store bytes in a circular buffer of DEPTH entries with read and write pointers that wrap from DEPTH-1 to 0.
REQ-015 SHALL accept a write on a cycle with wr_en=1 and full=0: wr_data is stored at the write pointer, the pointer advances, and count increments.
REQ-016 SHALL ignore a write on a cycle with wr_en=1 and full=1, leave contents and count unchanged, and drive overflow=1 for exactly the following cycle.
REQ-017 SHALL evaluate full from the registered count, so a write arriving in the same cycle as a pop while full is rejected.
REQ-018 SHALL hold count unchanged on a cycle with both an accepted write and a pop.
REQ-019 SHALL drive full, empty, and count as registered values consistent with the stored contents after every edge.
REQ-020 SHALL use a three-state sender FSM: IDLE, SETUP, STROBE.
REQ-021 In IDLE the FSM SHALL drive tx_send=0; when empty=0 and tx_rdy=1 it SHALL pop the head into tx_d, advance the read pointer, decrement count, and go to SETUP.
REQ-022 In SETUP the FSM SHALL keep tx_send=0 and tx_d stable for one cycle, then go to STROBE with tx_send<=1.
REQ-023 In STROBE the FSM SHALL hold tx_send=1 and tx_d stable while tx_rdy=1; on tx_rdy=0 it SHALL go to IDLE with tx_send<=0.
REQ-024 SHALL hold tx_d unchanged from a pop until the next pop; tx_d never changes while tx_send=1.
REQ-025 SHALL keep tx_send low for at least two cycles (the IDLE and SETUP cycles) between consecutive rising edges.
REQ-026 SHALL produce a tx_send rising edge 3 cycles after the accepting wr_en cycle, for a write into an empty queue with the FSM in IDLE and tx_rdy=1.
REQ-027 SHALL send bytes strictly in write order, with no loss or duplication, across pointer wrap.
REQ-028 SHALL stall in IDLE without popping while tx_rdy=0; queued data is retained.
REQ-029 SHALL drive all outputs from registers.

Reset
REQ-030 On rst=1 at a clock edge, the block SHALL set pointers=0, count=0, empty=1, full=0, overflow=0, tx_d=8'h00, tx_send=0, and FSM=IDLE.
REQ-031 SHALL give rst priority over wr_en and the FSM; a write on a reset cycle is discarded.
REQ-032 On reset mid-operation, queued and in-flight bytes SHALL be discarded, and tx_send SHALL be 0 from the edge where rst is sampled.

Verification
REQ-033 The bench SHALL apply reset with wr_en=1 and wr_data=8'hA5, and check all REQ-030 values with no byte enqueued.
REQ-034 The bench SHALL write 8'h55 into an empty queue with tx_rdy=1, and check that tx_d=8'h55 and tx_send rises 3 cycles later; then drop tx_rdy and check that tx_send falls the next cycle.
REQ-035 The bench SHALL write 8'h01..8'h10 with DEPTH=16 and tx_rdy=0, and check full=1 and count=16; a 17th write SHALL give overflow=1 for one cycle and leave count=16.
REQ-036 The bench SHALL write 40 sequential bytes while emulating the downstream handshake, and check that the output order matches input order across wrap, with empty=1 at the end.
REQ-037 The bench SHALL issue a simultaneous write and pop with count=5, and check count stays 5; it SHALL also issue a write while full on the pop cycle and check the write is rejected.
REQ-038 The bench SHALL assert reset while the FSM is in STROBE with 3 bytes queued, and check tx_send=0, count=0, and that no further send occurs.
